// File: rtl/vector_dispatch_queue.sv
// vector_dispatch_queue
//   FIFO between a scalar core and a vector core. Each entry carries a
//   vector instruction word plus its two scalar operands. Popped loads and
//   stores are tracked by saturating-guarded outstanding counters that are
//   retired by completion pulses from the vector core; a load (store) at the
//   head is held back while its outstanding counter is at its maximum.
//
//   Optional feature macro: VDQ_BYPASS_EN
//     When defined, an instruction arriving at an empty queue is presented
//     to the vector core in the same cycle and, if accepted, never written.
//     When undefined, outputs depend only on registered state.
module vector_dispatch_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        v_instr_valid_i,
    input  logic [31:0] v_instruction_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output logic        vector_stall_o,
    output logic [31:0] vector_instr_o,
    output logic [31:0] rs1_o,
    output logic [31:0] rs2_o,
    output logic        vector_valid_o,
    input  logic        vector_ready_i,
    input  logic        v_load_done_i,
    input  logic        v_store_done_i,
    output logic        all_v_loads_executed_o,
    output logic        all_v_stores_executed_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      DEPTH_C   = (AW+1)'(DEPTH);
    localparam logic [AW:0]      CNT_ZERO  = {(AW+1){1'b0}};
    localparam logic [AW:0]      CNT_ONE   = (AW+1)'(1'b1);
    localparam logic [AW-1:0]    PTR_ONE   = AW'(1'b1);
    localparam logic [CNT_W-1:0] OUT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] OUT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] OUT_ONE   = CNT_W'(1'b1);
    localparam logic [6:0]       OPC_LOAD  = 7'b0000111;
    localparam logic [6:0]       OPC_STORE = 7'b0100111;

    // Storage and state
    logic [31:0]      instr_mem_r [DEPTH];
    logic [31:0]      rs1_mem_r   [DEPTH];
    logic [31:0]      rs2_mem_r   [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [AW:0]      q_loads_r;
    logic [AW:0]      q_stores_r;
    logic [CNT_W-1:0] load_cnt_r;
    logic [CNT_W-1:0] store_cnt_r;
    logic             stall_r;

    // Combinational helpers
    logic             empty_s;
    logic [31:0]      head_instr_s;
    logic             head_load_s;
    logic             head_store_s;
    logic             in_load_s;
    logic             in_store_s;
    logic             head_blocked_s;
    logic             push_s;
    logic             write_s;
    logic             pop_q_s;
    logic             pop_load_s;
    logic             pop_store_s;
    logic             load_dec_s;
    logic             store_dec_s;
    logic             valid_s;
    logic [31:0]      instr_out_s;
    logic [31:0]      rs1_out_s;
    logic [31:0]      rs2_out_s;
    logic [AW:0]      count_next_s;
    logic [AW:0]      q_loads_next_s;
    logic [AW:0]      q_stores_next_s;
    logic [CNT_W-1:0] load_cnt_next_s;
    logic [CNT_W-1:0] store_cnt_next_s;
`ifdef VDQ_BYPASS_EN
    logic             in_blocked_s;
    logic             bypass_s;
    logic             bypass_take_s;
`endif

    // Head inspection and classification of head and incoming instructions
    always_comb begin
        empty_s        = (count_r == CNT_ZERO);
        head_instr_s   = instr_mem_r[rd_ptr_r];
        head_load_s    = !empty_s && (head_instr_s[6:0] == OPC_LOAD);
        head_store_s   = !empty_s && (head_instr_s[6:0] == OPC_STORE);
        in_load_s      = (v_instruction_i[6:0] == OPC_LOAD);
        in_store_s     = (v_instruction_i[6:0] == OPC_STORE);
        head_blocked_s = (head_load_s  && (load_cnt_r  == OUT_MAX)) ||
                         (head_store_s && (store_cnt_r == OUT_MAX));
        push_s         = v_instr_valid_i && !stall_r;
    end

`ifdef VDQ_BYPASS_EN
    // Output selection with same-cycle bypass for an empty queue
    always_comb begin
        in_blocked_s  = (in_load_s  && (load_cnt_r  == OUT_MAX)) ||
                        (in_store_s && (store_cnt_r == OUT_MAX));
        bypass_s      = empty_s && v_instr_valid_i && !in_blocked_s && !reset;
        valid_s       = 1'b0;
        instr_out_s   = 32'h0000_0000;
        rs1_out_s     = 32'h0000_0000;
        rs2_out_s     = 32'h0000_0000;
        if (!empty_s) begin
            valid_s     = !head_blocked_s;
            instr_out_s = head_instr_s;
            rs1_out_s   = rs1_mem_r[rd_ptr_r];
            rs2_out_s   = rs2_mem_r[rd_ptr_r];
        end else if (bypass_s) begin
            valid_s     = 1'b1;
            instr_out_s = v_instruction_i;
            rs1_out_s   = rs1_i;
            rs2_out_s   = rs2_i;
        end else begin
            valid_s     = 1'b0;
        end
        bypass_take_s = bypass_s && vector_ready_i;
        pop_q_s       = !empty_s && valid_s && vector_ready_i;
        write_s       = push_s && !bypass_take_s;
        pop_load_s    = (pop_q_s && head_load_s)  || (bypass_take_s && in_load_s);
        pop_store_s   = (pop_q_s && head_store_s) || (bypass_take_s && in_store_s);
    end
`else
    // Output selection from registered head entry only
    always_comb begin
        valid_s     = 1'b0;
        instr_out_s = 32'h0000_0000;
        rs1_out_s   = 32'h0000_0000;
        rs2_out_s   = 32'h0000_0000;
        if (!empty_s) begin
            valid_s     = !head_blocked_s;
            instr_out_s = head_instr_s;
            rs1_out_s   = rs1_mem_r[rd_ptr_r];
            rs2_out_s   = rs2_mem_r[rd_ptr_r];
        end else begin
            valid_s     = 1'b0;
        end
        pop_q_s     = valid_s && vector_ready_i;
        write_s     = push_s;
        pop_load_s  = pop_q_s && head_load_s;
        pop_store_s = pop_q_s && head_store_s;
    end
`endif

    // Next-state for occupancy, queued load/store tallies and outstanding counters
    always_comb begin
        load_dec_s  = v_load_done_i  && (load_cnt_r  != OUT_ZERO);
        store_dec_s = v_store_done_i && (store_cnt_r != OUT_ZERO);

        case ({write_s, pop_q_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase

        case ({write_s && in_load_s, pop_q_s && head_load_s})
            2'b10:   q_loads_next_s = q_loads_r + CNT_ONE;
            2'b01:   q_loads_next_s = q_loads_r - CNT_ONE;
            default: q_loads_next_s = q_loads_r;
        endcase

        case ({write_s && in_store_s, pop_q_s && head_store_s})
            2'b10:   q_stores_next_s = q_stores_r + CNT_ONE;
            2'b01:   q_stores_next_s = q_stores_r - CNT_ONE;
            default: q_stores_next_s = q_stores_r;
        endcase

        case ({pop_load_s, load_dec_s})
            2'b10:   load_cnt_next_s = load_cnt_r + OUT_ONE;
            2'b01:   load_cnt_next_s = load_cnt_r - OUT_ONE;
            default: load_cnt_next_s = load_cnt_r;
        endcase

        case ({pop_store_s, store_dec_s})
            2'b10:   store_cnt_next_s = store_cnt_r + OUT_ONE;
            2'b01:   store_cnt_next_s = store_cnt_r - OUT_ONE;
            default: store_cnt_next_s = store_cnt_r;
        endcase
    end

    // Control state: pointers, occupancy, tallies, counters and registered stall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            count_r     <= CNT_ZERO;
            q_loads_r   <= CNT_ZERO;
            q_stores_r  <= CNT_ZERO;
            load_cnt_r  <= OUT_ZERO;
            store_cnt_r <= OUT_ZERO;
            stall_r     <= 1'b0;
        end else begin
            if (write_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_q_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r     <= count_next_s;
            q_loads_r   <= q_loads_next_s;
            q_stores_r  <= q_stores_next_s;
            load_cnt_r  <= load_cnt_next_s;
            store_cnt_r <= store_cnt_next_s;
            stall_r     <= (count_next_s == DEPTH_C);
        end
    end

    // Entry storage; contents are only visible through the occupancy-gated mux
    always_ff @(posedge clk) begin
        if (write_s) begin
            instr_mem_r[wr_ptr_r] <= v_instruction_i;
            rs1_mem_r[wr_ptr_r]   <= rs1_i;
            rs2_mem_r[wr_ptr_r]   <= rs2_i;
        end
    end

    assign vector_stall_o          = stall_r;
    assign vector_valid_o          = valid_s;
    assign vector_instr_o          = instr_out_s;
    assign rs1_o                   = rs1_out_s;
    assign rs2_o                   = rs2_out_s;
    assign all_v_loads_executed_o  = (load_cnt_r  == OUT_ZERO) && (q_loads_r  == CNT_ZERO);
    assign all_v_stores_executed_o = (store_cnt_r == OUT_ZERO) && (q_stores_r == CNT_ZERO);

endmodule

// File: tb/tb_vector_dispatch_queue.sv
// Testbench for vector_dispatch_queue (default build, DEPTH=4, CNT_W=4).
// A queue-based reference model is advanced and compared on every falling
// edge; directed sequences add hand-computed literal checks.
module tb_vector_dispatch_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    localparam logic [31:0] I_LOAD  = 32'h0205_8007;
    localparam logic [31:0] I_STORE = 32'h0205_8027;
    localparam logic [31:0] I_ARITH = 32'h0000_0057;

    logic        clk = 1'b0;
    logic        reset;
    logic        v_instr_valid_i;
    logic [31:0] v_instruction_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        vector_stall_o;
    logic [31:0] vector_instr_o;
    logic [31:0] rs1_o;
    logic [31:0] rs2_o;
    logic        vector_valid_o;
    logic        vector_ready_i;
    logic        v_load_done_i;
    logic        v_store_done_i;
    logic        all_v_loads_executed_o;
    logic        all_v_stores_executed_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } ent_t;

    ent_t m_q[$];
    int   m_ld = 0;
    int   m_st = 0;

    vector_dispatch_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .v_instr_valid_i         (v_instr_valid_i),
        .v_instruction_i         (v_instruction_i),
        .rs1_i                   (rs1_i),
        .rs2_i                   (rs2_i),
        .vector_stall_o          (vector_stall_o),
        .vector_instr_o          (vector_instr_o),
        .rs1_o                   (rs1_o),
        .rs2_o                   (rs2_o),
        .vector_valid_o          (vector_valid_o),
        .vector_ready_i          (vector_ready_i),
        .v_load_done_i           (v_load_done_i),
        .v_store_done_i          (v_store_done_i),
        .all_v_loads_executed_o  (all_v_loads_executed_o),
        .all_v_stores_executed_o (all_v_stores_executed_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_ld(input logic [31:0] i);
        return i[6:0] == 7'b0000111;
    endfunction

    function automatic bit is_st(input logic [31:0] i);
        return i[6:0] == 7'b0100111;
    endfunction

    // Reference model: compare outputs mid-cycle, then apply this cycle's transfer
    always @(negedge clk) begin
        ent_t h;
        int   nl, ns, inc_l, inc_s, dec_l, dec_s;
        bit   blk, e_valid, e_stall, pop, push;
        if (reset) begin
            m_q.delete();
            m_ld = 0;
            m_st = 0;
        end
        h  = '0;
        nl = 0;
        ns = 0;
        foreach (m_q[k]) begin
            if (is_ld(m_q[k].instr)) nl++;
            if (is_st(m_q[k].instr)) ns++;
        end
        if (m_q.size() > 0) h = m_q[0];
        blk     = (m_q.size() > 0) &&
                  ((is_ld(h.instr) && m_ld == CMAX) || (is_st(h.instr) && m_st == CMAX));
        e_valid = (m_q.size() > 0) && !blk;
        e_stall = (m_q.size() == DEPTH);
        chk("m_valid", 32'(vector_valid_o), 32'(e_valid));
        chk("m_stall", 32'(vector_stall_o), 32'(e_stall));
        chk("m_instr", vector_instr_o, h.instr);
        chk("m_rs1", rs1_o, h.rs1);
        chk("m_rs2", rs2_o, h.rs2);
        chk("m_ld_exec", 32'(all_v_loads_executed_o), 32'(m_ld == 0 && nl == 0));
        chk("m_st_exec", 32'(all_v_stores_executed_o), 32'(m_st == 0 && ns == 0));
        if (!reset) begin
            pop   = e_valid && vector_ready_i;
            push  = v_instr_valid_i && !e_stall;
            inc_l = (pop && is_ld(h.instr)) ? 1 : 0;
            inc_s = (pop && is_st(h.instr)) ? 1 : 0;
            dec_l = (v_load_done_i && m_ld > 0) ? 1 : 0;
            dec_s = (v_store_done_i && m_st > 0) ? 1 : 0;
            m_ld  = m_ld + inc_l - dec_l;
            m_st  = m_st + inc_s - dec_s;
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back({v_instruction_i, rs1_i, rs2_i});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        v_instr_valid_i = 1'b1;
        v_instruction_i = i;
        rs1_i           = a;
        rs2_i           = b;
    endtask

    initial begin
        reset           = 1'b1;
        v_instr_valid_i = 1'b0;
        v_instruction_i = 32'h0;
        rs1_i           = 32'h0;
        rs2_i           = 32'h0;
        vector_ready_i  = 1'b0;
        v_load_done_i   = 1'b0;
        v_store_done_i  = 1'b0;
        cyc();
        chk("rst_valid", 32'(vector_valid_o), 32'd0);
        chk("rst_stall", 32'(vector_stall_o), 32'd0);
        chk("rst_ld_exec", 32'(all_v_loads_executed_o), 32'd1);
        cyc();
        reset = 1'b0;

        // Single load: one-cycle latency, executed flag until done pulse
        drive(I_LOAD, 32'h0000_1000, 32'h0000_0002);
        #1;
        chk("lat_not_same_cycle", 32'(vector_valid_o), 32'd0);
        cyc();
        v_instr_valid_i = 1'b0;
        chk("lat_valid", 32'(vector_valid_o), 32'd1);
        chk("lat_instr", vector_instr_o, 32'h0205_8007);
        chk("lat_rs1", rs1_o, 32'h0000_1000);
        chk("lat_ld_exec_queued", 32'(all_v_loads_executed_o), 32'd0);
        vector_ready_i = 1'b1;
        cyc();
        vector_ready_i = 1'b0;
        chk("lat_ld_exec_out", 32'(all_v_loads_executed_o), 32'd0);
        v_load_done_i = 1'b1;
        cyc();
        v_load_done_i = 1'b0;
        chk("lat_ld_exec_done", 32'(all_v_loads_executed_o), 32'd1);

        // Fill to full with ready low; fifth push rejected
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       drive(I_ARITH, 32'h11, 32'h0);
                1:       drive(I_STORE, 32'h22, 32'h0);
                2:       drive(I_ARITH, 32'h33, 32'h0);
                default: drive(I_LOAD,  32'h44, 32'h0);
            endcase
            cyc();
        end
        chk("full_stall", 32'(vector_stall_o), 32'd1);
        drive(I_ARITH, 32'h55, 32'h0);
        cyc();
        chk("full_head_rs1", rs1_o, 32'h11);
        chk("full_stall_hold", 32'(vector_stall_o), 32'd1);

        // Full with push and pop together: pop only, count 3
        vector_ready_i = 1'b1;
        cyc();
        v_instr_valid_i = 1'b0;
        vector_ready_i  = 1'b0;
        chk("fpp_stall", 32'(vector_stall_o), 32'd0);
        chk("fpp_head_rs1", rs1_o, 32'h22);
        drive(I_ARITH, 32'h66, 32'h0);
        cyc();
        v_instr_valid_i = 1'b0;
        chk("fpp_refill_stall", 32'(vector_stall_o), 32'd1);
        vector_ready_i = 1'b1;
        repeat (4) cyc();
        vector_ready_i = 1'b0;
        v_load_done_i  = 1'b1;
        v_store_done_i = 1'b1;
        repeat (2) cyc();
        v_load_done_i  = 1'b0;
        v_store_done_i = 1'b0;
        chk("drain_st_exec", 32'(all_v_stores_executed_o), 32'd1);
        chk("drain_ld_exec", 32'(all_v_loads_executed_o), 32'd1);

        // Sixteen stores with no completions: the last is held at the head
        vector_ready_i = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            drive(I_STORE, 32'(i), 32'h0);
            cyc();
        end
        v_instr_valid_i = 1'b0;
        chk("sat_valid_low", 32'(vector_valid_o), 32'd0);
        repeat (3) cyc();
        chk("sat_valid_still_low", 32'(vector_valid_o), 32'd0);
        chk("sat_head_rs1", rs1_o, 32'd16);
        v_store_done_i = 1'b1;
        cyc();
        v_store_done_i = 1'b0;
        chk("sat_release_valid", 32'(vector_valid_o), 32'd1);
        chk("sat_release_rs1", rs1_o, 32'd16);
        cyc();
        vector_ready_i = 1'b0;
        v_store_done_i = 1'b1;
        repeat (14) cyc();
        chk("sat_st_exec_one_left", 32'(all_v_stores_executed_o), 32'd0);
        cyc();
        v_store_done_i = 1'b0;
        chk("sat_st_exec_clear", 32'(all_v_stores_executed_o), 32'd1);

        // Done pulse at zero ignored; pop with done at counter 2 keeps 2
        v_load_done_i = 1'b1;
        cyc();
        v_load_done_i = 1'b0;
        chk("uf_ld_exec", 32'(all_v_loads_executed_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(I_LOAD, 32'(32'h100 + i), 32'h0);
            cyc();
        end
        v_instr_valid_i = 1'b0;
        vector_ready_i  = 1'b1;
        repeat (2) cyc();
        v_load_done_i = 1'b1;
        cyc();
        vector_ready_i = 1'b0;
        cyc();
        chk("pd_ld_exec_one_left", 32'(all_v_loads_executed_o), 32'd0);
        cyc();
        v_load_done_i = 1'b0;
        chk("pd_ld_exec_clear", 32'(all_v_loads_executed_o), 32'd1);

        // Asynchronous reset with entries queued and counters non-zero
        drive(I_LOAD, 32'h7, 32'h0);
        cyc();
        drive(I_STORE, 32'h8, 32'h0);
        cyc();
        v_instr_valid_i = 1'b0;
        vector_ready_i  = 1'b1;
        repeat (2) cyc();
        vector_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(I_ARITH, 32'(32'h200 + i), 32'h9);
            cyc();
        end
        v_instr_valid_i = 1'b0;
        chk("ar_pre_ld_exec", 32'(all_v_loads_executed_o), 32'd0);
        chk("ar_pre_valid", 32'(vector_valid_o), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_valid", 32'(vector_valid_o), 32'd0);
        chk("ar_stall", 32'(vector_stall_o), 32'd0);
        chk("ar_instr", vector_instr_o, 32'd0);
        chk("ar_rs1", rs1_o, 32'd0);
        chk("ar_rs2", rs2_o, 32'd0);
        chk("ar_ld_exec", 32'(all_v_loads_executed_o), 32'd1);
        chk("ar_st_exec", 32'(all_v_stores_executed_o), 32'd1);
        cyc();
        reset = 1'b0;
        drive(32'h0000_A057, 32'h0000_ABCD, 32'h0000_1234);
        cyc();
        v_instr_valid_i = 1'b0;
        chk("ar_new_valid", 32'(vector_valid_o), 32'd1);
        chk("ar_new_instr", vector_instr_o, 32'h0000_A057);
        chk("ar_new_rs1", rs1_o, 32'h0000_ABCD);
        chk("ar_new_rs2", rs2_o, 32'h0000_1234);
        vector_ready_i = 1'b1;
        cyc();
        vector_ready_i = 1'b0;
        repeat (2) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vector_dispatch_queue.md
VECTOR_DISPATCH_QUEUE -- requirements
Module: vector_dispatch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; power of two, minimum 2.
REQ-002 Parameter CNT_W, default 4, width of each outstanding load/store counter.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 v_instr_valid_i  input  1  scalar core presents a vector instruction.
REQ-006 v_instruction_i, rs1_i, rs2_i  input  32 each  instruction word and scalar operands from the scalar core.
REQ-007 vector_stall_o  output  1  back-pressure to the scalar core; high when the queue is full.
REQ-008 vector_instr_o, rs1_o, rs2_o  output  32 each  head entry to the vector core.
REQ-009 vector_valid_o  output  1  head entry valid.
REQ-010 vector_ready_i  input  1  vector core accepts the head entry (inverse of its stall).
REQ-011 v_load_done_i, v_store_done_i  input  1 each  single-cycle completion pulses from the vector core.
REQ-012 all_v_loads_executed_o, all_v_stores_executed_o  output  1 each  high when the corresponding outstanding count is 0 and the queue holds no load/store respectively.

Function
REQ-013 Push occurs when v_instr_valid_i=1 and vector_stall_o=0; the entry {instr, rs1, rs2} is written at the tail.
REQ-014 Pop occurs when vector_valid_o=1 and vector_ready_i=1; the head advances.
REQ-015 vector_stall_o is registered: it equals (count==DEPTH). A pop in the same cycle as full does not admit a push.
REQ-016 A push and a pop in the same cycle leave the count unchanged; pointers wrap modulo DEPTH.
REQ-017 Entry classification from instr[6:0]: 0000111 is a load and 0100111 is a store; any other value is neither.
REQ-018 Popping a load increments the load counter; a v_load_done_i pulse decrements it; both in the same cycle leave it unchanged. The store counter behaves identically.
REQ-019 A done pulse while the counter is 0 is ignored; the counter never underflows.
REQ-020 While the load (store) counter equals 2^CNT_W-1, vector_valid_o is forced low if the head is a load (store). The head is held until a done pulse arrives.
REQ-021 The queue keeps separate counts of queued loads and queued stores; these feed REQ-012.
REQ-022 The *_executed_o outputs are combinational from registered state.
REQ-023 Minimum latency from push to vector_valid_o is 1 cycle, unless the bypass of REQ-026 applies.
REQ-024 Output data is held stable while vector_valid_o=1 and vector_ready_i=0.

Reset
REQ-025 Reset, asserted at any time including mid-transfer, clears pointers, counts and counters. Outputs go to: vector_valid_o=0, vector_stall_o=0, data outputs=0, both *_executed_o=1. Any in-flight entries are discarded.

Configuration
REQ-026 Macro VDQ_BYPASS_EN, when defined, enables the bypass: if the queue is empty, v_instr_valid_i=1 and REQ-020 does not block, the input drives the outputs with vector_valid_o=1 in the same cycle. If vector_ready_i=1 the entry is consumed without being written. When the macro is undefined, there is no combinational path from input to output and REQ-023 applies strictly.

Verification
REQ-027 Reset, then push the load 0x02058007 with rs1=0x1000 -> vector_valid_o=1 on the next cycle (same cycle with VDQ_BYPASS_EN), and all_v_loads_executed_o=0 until the pop and v_load_done_i.
REQ-028 Hold vector_ready_i=0 and push 4 entries (DEPTH=4) -> vector_stall_o=1 after the 4th push; a 5th valid is not accepted; head data unchanged.
REQ-029 Queue full with simultaneous push and pop -> pop occurs, push rejected, count becomes 3, vector_stall_o=0 on the next cycle.
REQ-030 Issue 15 stores with no done pulses (CNT_W=4), 16th entry is a store -> vector_valid_o stays 0. One v_store_done_i pulse -> the 16th store issues on the following cycle.
REQ-031 v_load_done_i pulse with the counter at 0 -> counter stays 0 and all_v_loads_executed_o stays 1. Pop of a load in the same cycle as a done pulse with counter=2 -> counter stays 2.
REQ-032 Assert reset with 3 entries queued and the counters non-zero -> all outputs at REQ-025 values immediately, asynchronously; after release the first new push is output with the correct data.
